// File: rtl/decode_stage.sv
// decode_stage: registered ID/EX stage. Decodes R/I-type words, holds them
// behind a valid/ready handshake, and inserts one bubble per load-use hazard.
// Optional: define DECODE_ILLEGAL_TRAP_EN to flag unrecognised encodings.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_inst,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_dest,
  output logic [XLEN-1:0]    out_imm,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic               out_insttype,
  output logic               out_regwrite,
  output logic               out_memwrite,
  output logic               out_memtoreg,
  output logic               out_branch,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);

  typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_t;

  // Decoded view of the incoming word
  logic [5:0]         opcode, funct;
  logic [4:0]         dec_rs, dec_rt, dec_dest;
  logic [XLEN-1:0]    dec_imm;
  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_insttype, dec_regwrite, dec_memwrite, dec_memtoreg;
  logic               dec_branch, dec_illegal, dec_known, dec_reads_rt, dec_is_lw;

  // ID/EX register, hazard tracker and FSM state
  logic               out_valid_q, out_valid_d;
  logic [4:0]         rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic               insttype_q, insttype_d, regwrite_q, regwrite_d;
  logic               memwrite_q, memwrite_d, memtoreg_q, memtoreg_d;
  logic               branch_q, branch_d, illegal_q, illegal_d;
  logic               ld_pend_q, ld_pend_d;
  logic [4:0]         ld_dest_q, ld_dest_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  state_t             state_q, state_d;

  logic adv, hazard, stall_now, transfer;

  assign opcode  = in_inst[31:26];
  assign funct   = in_inst[5:0];
  assign dec_rs  = in_inst[25:21];
  assign dec_rt  = in_inst[20:16];
  assign dec_imm = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};

  // Instruction decode table, with unknown-encoding handling selected at build time
  always_comb begin
    dec_aluop    = ALU_ADD;
    dec_insttype = (opcode != OP_RTYPE);
    dec_dest     = (opcode == OP_RTYPE) ? in_inst[15:11] : dec_rt;
    dec_regwrite = 1'b0;
    dec_memwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_branch   = 1'b0;
    dec_illegal  = 1'b0;
    dec_known    = 1'b1;
    dec_is_lw    = 1'b0;
    dec_reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW);
    if (opcode == OP_RTYPE) begin
      dec_regwrite = 1'b1;
      case (funct)
        6'b100000: dec_aluop = ALU_ADD;
        6'b100010: dec_aluop = ALU_SUB;
        6'b100100: dec_aluop = ALU_AND;
        6'b100101: dec_aluop = ALU_OR;
        6'b101010: dec_aluop = ALU_SLT;
        default:   dec_known = 1'b0;
      endcase
    end else begin
      case (opcode)
        OP_ADDI: dec_regwrite = 1'b1;
        OP_LW: begin
          dec_regwrite = 1'b1;
          dec_memtoreg = 1'b1;
          dec_is_lw    = 1'b1;
        end
        OP_SW:   dec_memwrite = 1'b1;
        OP_BGTZ: dec_branch   = 1'b1;
        default: dec_known    = 1'b0;
      endcase
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (!dec_known) begin
      dec_illegal  = 1'b1;
      dec_aluop    = ALU_ADD;
      dec_regwrite = 1'b0;
      dec_memwrite = 1'b0;
      dec_memtoreg = 1'b0;
      dec_branch   = 1'b0;
    end
`else
    if (!dec_known) begin
      dec_aluop    = ALU_ADD;
      dec_regwrite = 1'b1;
    end
`endif
    // Writes to r0 are architecturally dropped
    if (dec_dest == 5'd0) dec_regwrite = 1'b0;
  end

  assign adv       = !out_valid_q || out_ready;
  assign hazard    = in_valid && ld_pend_q && (ld_dest_q != 5'd0) &&
                     ((ld_dest_q == dec_rs) || (dec_reads_rt && (ld_dest_q == dec_rt)));
  assign stall_now = (state_q == ST_RUN) && hazard;
  assign transfer  = in_valid && in_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: a bubble lasts exactly one advancing edge
  always_comb begin
    state_d = state_q;
    if (flush)          state_d = ST_RUN;
    else if (adv)       state_d = stall_now ? ST_BUBBLE : ST_RUN;
  end

  // FSM outputs: ready never depends on itself, only on out_ready and hazard
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (state_q == ST_BUBBLE) in_ready = adv;
      else                      in_ready = adv && !hazard;
    end
  end

  // ID/EX register, hazard tracker and stall counter next values
  always_comb begin
    out_valid_d = out_valid_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    dest_d      = dest_q;
    imm_d       = imm_q;
    aluop_d     = aluop_q;
    insttype_d  = insttype_q;
    regwrite_d  = regwrite_q;
    memwrite_d  = memwrite_q;
    memtoreg_d  = memtoreg_q;
    branch_d    = branch_q;
    illegal_d   = illegal_q;
    ld_pend_d   = ld_pend_q;
    ld_dest_d   = ld_dest_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
      ld_pend_d   = 1'b0;
    end else if (adv) begin
      if (stall_now) begin
        out_valid_d = 1'b0;
        ld_pend_d   = 1'b0;
        if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else if (transfer) begin
        out_valid_d = 1'b1;
        rs_d        = dec_rs;
        rt_d        = dec_rt;
        dest_d      = dec_dest;
        imm_d       = dec_imm;
        aluop_d     = dec_aluop;
        insttype_d  = dec_insttype;
        regwrite_d  = dec_regwrite;
        memwrite_d  = dec_memwrite;
        memtoreg_d  = dec_memtoreg;
        branch_d    = dec_branch;
        illegal_d   = dec_illegal;
        ld_pend_d   = dec_is_lw;
        ld_dest_d   = dec_dest;
      end else begin
        out_valid_d = 1'b0;
        ld_pend_d   = 1'b0;
      end
    end
  end

  // Datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      dest_q      <= '0;
      imm_q       <= '0;
      aluop_q     <= '0;
      insttype_q  <= 1'b0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
      ld_pend_q   <= 1'b0;
      ld_dest_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dest_q      <= dest_d;
      imm_q       <= imm_d;
      aluop_q     <= aluop_d;
      insttype_q  <= insttype_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      memtoreg_q  <= memtoreg_d;
      branch_q    <= branch_d;
      illegal_q   <= illegal_d;
      ld_pend_q   <= ld_pend_d;
      ld_dest_q   <= ld_dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs       = rs_q;
  assign out_rt       = rt_q;
  assign out_dest     = dest_q;
  assign out_imm      = imm_q;
  assign out_aluop    = aluop_q;
  assign out_insttype = insttype_q;
  assign out_regwrite = regwrite_q;
  assign out_memwrite = memwrite_q;
  assign out_memtoreg = memtoreg_q;
  assign out_branch   = branch_q;
  assign out_illegal  = illegal_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table-driven reference decoder plus a transaction
// model of the ID/EX register, checked every cycle, with directed vectors.
module tb_decode_stage;

  localparam int TB_CNT_W = 2;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_rs, out_rt, out_dest;
  logic [31:0] out_imm;
  logic [2:0]  out_aluop;
  logic        out_insttype, out_regwrite, out_memwrite, out_memtoreg;
  logic        out_branch, out_illegal;
  logic [TB_CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  decode_stage #(.XLEN(32), .ALUOP_W(3), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest), .out_imm(out_imm),
    .out_aluop(out_aluop), .out_insttype(out_insttype), .out_regwrite(out_regwrite),
    .out_memwrite(out_memwrite), .out_memtoreg(out_memtoreg), .out_branch(out_branch),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [2:0]  aluop;
    logic        insttype, regwrite, memwrite, memtoreg, branch, illegal;
    logic        reads_rt, is_lw;
  } dec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder straight from the instruction table
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    bit known;
    d = '0;
    known = 1'b1;
    d.rs  = w[25:21];
    d.rt  = w[20:16];
    d.imm = {{16{w[15]}}, w[15:0]};
    if (w[31:26] == 6'd0) begin
      d.dest = w[15:11];
      d.reads_rt = 1'b1;
      d.regwrite = 1'b1;
      case (w[5:0])
        6'h20: d.aluop = 3'd0;
        6'h22: d.aluop = 3'd1;
        6'h24: d.aluop = 3'd2;
        6'h25: d.aluop = 3'd3;
        6'h2A: d.aluop = 3'd4;
        default: known = 1'b0;
      endcase
    end else begin
      d.insttype = 1'b1;
      d.dest = w[20:16];
      case (w[31:26])
        6'h08: d.regwrite = 1'b1;
        6'h23: begin d.regwrite = 1'b1; d.memtoreg = 1'b1; d.is_lw = 1'b1; end
        6'h2B: begin d.memwrite = 1'b1; d.reads_rt = 1'b1; end
        6'h07: d.branch = 1'b1;
        default: known = 1'b0;
      endcase
    end
    if (!known) begin
      d.aluop = 3'd0;
      if (TRAP) begin
        d.illegal = 1'b1;
        d.regwrite = 1'b0; d.memwrite = 1'b0; d.memtoreg = 1'b0; d.branch = 1'b0;
      end else begin
        d.regwrite = 1'b1;
      end
    end
    if (d.dest == 5'd0) d.regwrite = 1'b0;
    return d;
  endfunction

  // Transaction model: what the ID/EX register must hold after each edge
  dec_t m_held, m_in;
  bit   m_valid, m_owe_bubble_done, m_load_live;
  logic [4:0] m_load_dest;
  int   m_stalls;
  bit   m_adv, m_conflict, m_rdy;
  logic [55:0] act_f, exp_f;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_fields", {out_rs, out_rt, out_dest, out_imm, out_aluop, out_insttype,
          out_regwrite, out_memwrite, out_memtoreg, out_branch, out_illegal}, 0);
      m_valid = 0; m_load_live = 0; m_load_dest = 0; m_stalls = 0;
      m_owe_bubble_done = 0; m_held = '0;
    end else begin
      m_in = ref_dec(in_inst);
      m_adv = !m_valid || out_ready;
      m_conflict = in_valid && m_load_live && m_load_dest != 0 &&
                   (m_load_dest == m_in.rs || (m_in.reads_rt && m_load_dest == m_in.rt));
      m_rdy = m_adv && (m_owe_bubble_done || !m_conflict);
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, m_valid);
      chk("stall_cnt", stall_cnt, m_stalls);
      if (m_valid) begin
        act_f = {out_rs, out_rt, out_dest, out_imm, out_aluop, out_insttype,
                 out_regwrite, out_memwrite, out_memtoreg, out_branch, out_illegal};
        exp_f = {m_held.rs, m_held.rt, m_held.dest, m_held.imm, m_held.aluop, m_held.insttype,
                 m_held.regwrite, m_held.memwrite, m_held.memtoreg, m_held.branch, m_held.illegal};
        chk("fields", act_f, exp_f);
      end
      if (flush) begin
        m_valid = 0; m_load_live = 0; m_owe_bubble_done = 0;
        $display("flush t=%0t", $time);
      end else if (m_adv) begin
        if (m_conflict && !m_owe_bubble_done) begin
          m_valid = 0; m_load_live = 0; m_owe_bubble_done = 1;
          if (m_stalls < (1 << TB_CNT_W) - 1) m_stalls++;
          $display("bubble t=%0t", $time);
        end else if (in_valid && m_rdy) begin
          m_held = m_in; m_valid = 1; m_owe_bubble_done = 0;
          m_load_live = m_in.is_lw; m_load_dest = m_in.dest;
          $display("xfer t=%0t inst=%h", $time, in_inst);
        end else begin
          m_valid = 0; m_load_live = 0; m_owe_bubble_done = 0;
        end
      end
    end
  end

  // Present a word until it is accepted; cycles reports how many edges it took
  task automatic send(input logic [31:0] w, output int cycles);
    bit acc;
    acc = 0;
    cycles = 0;
    in_valid = 1'b1;
    in_inst = w;
    while (!acc && cycles < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int c;
  logic [31:0] mix [6] = '{32'h0085102A, 32'h00851024, 32'h00851025,
                           32'h1C200010, 32'h0085103F, 32'h20000001};

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming with full throughput
    send(32'h00851020, c);
    chk("add_aluop", out_aluop, 0); chk("add_dest", out_dest, 2);
    send(32'h00851022, c);
    chk("sub_aluop", out_aluop, 1); chk("sub_lat", c, 1);
    send(32'h20A5000F, c);
    chk("addi_dest", out_dest, 5); chk("addi_imm", out_imm, 32'h0000000F);
    send(32'h2005FFFF, c);
    chk("neg_imm", out_imm, 32'hFFFFFFFF);
    foreach (mix[i]) send(mix[i], c);
    idle(1);

    // Load-use: one bubble
    send(32'h8C220004, c);
    send(32'h00431020, c);
    chk("lu_cycles", c, 2); chk("lu_stalls", stall_cnt, 1); chk("lu_valid", out_valid, 1);
    // Load to r0: no bubble
    send(32'h8C200004, c);
    send(32'h00011020, c);
    chk("lu0_cycles", c, 1); chk("lu0_stalls", stall_cnt, 1);

    // Backpressure with a held SW
    send(32'hAC220008, c);
    out_ready = 1'b0;
    in_inst = 32'h1C200010;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", in_ready, 0); chk("bp_memwrite", out_memwrite, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_branch", out_branch, 1);
    idle(1);

    // Flush while a load and its dependant are both present
    send(32'h8C220004, c);
    in_inst = 32'h00431020;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_valid", out_valid, 0); chk("fl_stalls", stall_cnt, 1);
    send(32'h00431020, c);
    chk("fl_nohaz", c, 1);

    // Unrecognised opcode
    send(32'hFC220004, c);
    chk("ill_flag", out_illegal, TRAP); chk("ill_regwrite", out_regwrite, !TRAP);
    chk("ill_valid", out_valid, 1);
    in_valid = 1'b0;

    // Asynchronous reset mid-stream
    send(32'h00851020, c);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0); chk("ar_ready", in_ready, 0);
    chk("ar_dest", out_dest, 0); chk("ar_stalls", stall_cnt, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h00851020, c);
    chk("ar_first", out_valid, 1); chk("ar_first_lat", c, 1);

    // Stall counter saturation at all-ones
    for (int k = 0; k < 4; k++) begin
      send(32'h8C220004, c);
      send(32'h00431020, c);
    end
    idle(2);
    chk("sat_stalls", stall_cnt, 3);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
